// File: rtl/etc_rgb_block_pixel_scheduler.sv
// etc_rgb_block_pixel_scheduler: walks the ETC generator over each 4x4 block and streams address-tagged RGBA pixels
module etc_rgb_block_pixel_scheduler #(
    parameter int IMG_W_BLK = 64,
    parameter int IMG_H_BLK = 64,
    parameter int ADDR_W    = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic              sclk,
    input  logic              rsrt,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [63:0]       blk_data,
    input  logic              blk_flipped,
    input  logic              blk_punchThrough,
    input  logic              blk_alpha,
    input  logic [23:0]       blk_baseColor_0,
    input  logic [23:0]       blk_baseColor_1,
    output logic              dec_rsrt,
    output logic              dec_rtr,
    output logic [3:0]        dec_pixIdx,
    output logic [63:0]       dec_block,
    output logic              dec_flipped,
    output logic              dec_flag_punchThrough,
    output logic              dec_aplha,
    output logic [23:0]       dec_baseColor_0,
    output logic [23:0]       dec_baseColor_1,
    input  logic [7:0]        dec_r,
    input  logic [7:0]        dec_g,
    input  logic [7:0]        dec_b,
    input  logic [7:0]        dec_a,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    output logic [7:0]        pix_a,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_last,
    output logic              frame_done
);
    localparam int BX_W = IMG_W_BLK > 1 ? $clog2(IMG_W_BLK) : 1;
    localparam int BY_W = IMG_H_BLK > 1 ? $clog2(IMG_H_BLK) : 1;
    localparam int PW   = $clog2(OUT_DEPTH);
    localparam int CW   = $clog2(OUT_DEPTH + 1);
    localparam int FW   = 33 + ADDR_W;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;

    logic [BX_W-1:0]   bx;
    logic [BY_W-1:0]   by;
    logic              bx_wrap, inflight, tag_last, issue_last, pop;
    logic [ADDR_W-1:0] tag_addr, issue_addr;
    logic [FW-1:0]     mem [OUT_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;

    assign dec_rsrt   = ~rsrt;
    assign bx_wrap    = bx == BX_W'(IMG_W_BLK - 1);
    assign issue_addr = ADDR_W'((32'(by) * 4 + 32'(dec_pixIdx[1:0])) * 32'(4 * IMG_W_BLK)
                                + 32'(bx) * 4 + 32'(dec_pixIdx[3:2]));
    assign issue_last = bx_wrap && by == BY_W'(IMG_H_BLK - 1) && &dec_pixIdx;
    assign pix_valid  = cnt != '0;
    assign pop        = pix_valid && pix_ready;
    assign {pix_last, pix_addr, pix_r, pix_g, pix_b, pix_a} = mem[rp];

    // Issue only when the FIFO can absorb every pixel already requested, so it never overflows
    always_comb begin
        blk_ready = state == IDLE && rsrt;
        dec_rtr   = state == RUN && (32'(cnt) + 32'(inflight) < OUT_DEPTH);
        state_d   = blk_ready && blk_valid ? RUN : (dec_rtr && &dec_pixIdx) ? IDLE : state;
    end

    always_ff @(posedge sclk) begin
        if (!rsrt) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge sclk) begin
        if (!rsrt) begin
            dec_pixIdx            <= '0;
            dec_block             <= '0;
            dec_flipped           <= 1'b0;
            dec_flag_punchThrough <= 1'b0;
            dec_aplha             <= 1'b0;
            dec_baseColor_0       <= '0;
            dec_baseColor_1       <= '0;
            bx                    <= '0;
            by                    <= '0;
            inflight              <= 1'b0;
            tag_addr              <= '0;
            tag_last              <= 1'b0;
            wp                    <= '0;
            rp                    <= '0;
            cnt                   <= '0;
            frame_done            <= 1'b0;
        end else begin
            if (blk_ready && blk_valid) begin
                dec_pixIdx            <= '0;
                dec_block             <= blk_data;
                dec_flipped           <= blk_flipped;
                dec_flag_punchThrough <= blk_punchThrough;
                dec_aplha             <= blk_alpha;
                dec_baseColor_0       <= blk_baseColor_0;
                dec_baseColor_1       <= blk_baseColor_1;
            end
            if (dec_rtr) begin
                dec_pixIdx <= dec_pixIdx + 1'b1;
                tag_addr   <= issue_addr;
                tag_last   <= issue_last;
                if (&dec_pixIdx) begin
                    bx <= bx_wrap ? '0 : bx + 1'b1;
                    if (bx_wrap) by <= by == BY_W'(IMG_H_BLK - 1) ? '0 : by + 1'b1;
                end
            end
            inflight <= dec_rtr;
            if (inflight) wp <= wp == PW'(OUT_DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == PW'(OUT_DEPTH - 1) ? '0 : rp + 1'b1;
            cnt        <= cnt + CW'(inflight) - CW'(pop);
            frame_done <= pop && pix_last;
        end
    end

    // The generator's colour lands one cycle after the request that produced it
    always_ff @(posedge sclk) begin
        if (!rsrt) for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        else if (inflight) mem[wp] <= {tag_last, tag_addr, dec_r, dec_g, dec_b, dec_a};
    end
endmodule

// File: tb/tb_etc_rgb_block_pixel_scheduler.sv
// tb_etc_rgb_block_pixel_scheduler: directed tests of the block pixel scheduler on a 2x2-block image
module tb_etc_rgb_block_pixel_scheduler;
    localparam int D = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        fl;
        logic        pt;
        logic        al;
        logic [23:0] b0;
        logic [23:0] b1;
    } ctx_t;

    typedef struct packed {
        logic        last;
        logic [7:0]  addr;
        logic [31:0] rgba;
    } pix_t;

    logic        sclk = 1'b0, rsrt = 1'b0, blk_valid = 1'b0, pix_ready = 1'b0;
    ctx_t        cur = '0;
    logic        blk_ready, dec_rsrt, dec_rtr, dec_flipped, dec_flag_punchThrough, dec_aplha;
    logic [3:0]  dec_pixIdx;
    logic [63:0] dec_block;
    logic [23:0] dec_baseColor_0, dec_baseColor_1;
    logic [31:0] gen_q;
    logic        pix_valid, pix_last, frame_done;
    logic [7:0]  pix_r, pix_g, pix_b, pix_a, pix_addr;
    ctx_t        dctx;

    int   checks = 0, errors = 0;
    int   rtr_n, viol, fd_n, outst;
    pix_t got_q[$];
    ctx_t ctxq[$];

    always #5 sclk = ~sclk;

    etc_rgb_block_pixel_scheduler #(.IMG_W_BLK(2), .IMG_H_BLK(2), .ADDR_W(8), .OUT_DEPTH(D)) dut (
        .sclk(sclk), .rsrt(rsrt), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(cur.data), .blk_flipped(cur.fl), .blk_punchThrough(cur.pt), .blk_alpha(cur.al),
        .blk_baseColor_0(cur.b0), .blk_baseColor_1(cur.b1),
        .dec_rsrt(dec_rsrt), .dec_rtr(dec_rtr), .dec_pixIdx(dec_pixIdx), .dec_block(dec_block),
        .dec_flipped(dec_flipped), .dec_flag_punchThrough(dec_flag_punchThrough), .dec_aplha(dec_aplha),
        .dec_baseColor_0(dec_baseColor_0), .dec_baseColor_1(dec_baseColor_1),
        .dec_r(gen_q[31:24]), .dec_g(gen_q[23:16]), .dec_b(gen_q[15:8]), .dec_a(gen_q[7:0]),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_a(pix_a),
        .pix_addr(pix_addr), .pix_last(pix_last), .frame_done(frame_done)
    );

    // Simplified ETC1-style colour generator: {r,g,b,a}
    function automatic logic [31:0] gen(ctx_t c, logic [3:0] p);
        int ta[8];
        int tb[8];
        logic sub, msb, lsb;
        logic [23:0] base;
        logic [2:0] t;
        logic [31:0] res;
        int mag, d, v;
        ta = '{2, 5, 9, 13, 18, 24, 33, 47};
        tb = '{8, 17, 29, 42, 60, 80, 106, 183};
        sub  = c.fl ? p[1] : p[3];
        base = sub ? c.b1 : c.b0;
        t    = sub ? c.data[36:34] : c.data[39:37];
        msb  = c.data[16 + p];
        lsb  = c.data[p];
        mag  = lsb ? tb[t] : ta[t];
        d    = msb ? -mag : mag;
        for (int i = 0; i < 3; i++) begin
            v = int'(base[8*i +: 8]) + d;
            v = v < 0 ? 0 : v > 255 ? 255 : v;
            res[31 - 8*i -: 8] = 8'(v);
        end
        res[7:0] = c.al ? 8'hFF : (c.pt && msb && !lsb) ? 8'h00 : 8'hFF;
        return res;
    endfunction

    function automatic int exp_addr(int j);
        int k, p, bx, by;
        k  = j / 16;
        p  = j % 16;
        bx = k % 2;
        by = (k / 2) % 2;
        return (4 * by + p % 4) * 8 + 4 * bx + p / 4;
    endfunction

    assign dctx = {dec_block, dec_flipped, dec_flag_punchThrough, dec_aplha, dec_baseColor_0, dec_baseColor_1};

    always @(posedge sclk) begin
        if (dec_rsrt) gen_q <= '0;
        else if (dec_rtr) gen_q <= gen(dctx, dec_pixIdx);
    end

    always @(negedge sclk) begin
        if (!rsrt) begin
            got_q.delete();
            rtr_n = 0; viol = 0; fd_n = 0; outst = 0;
        end else begin
            if (dec_rtr) begin
                rtr_n++;
                if (outst >= D) viol++;
            end
            if (pix_valid && pix_ready) got_q.push_back({pix_last, pix_addr, pix_r, pix_g, pix_b, pix_a});
            if (frame_done) fd_n++;
            outst += int'(dec_rtr) - int'(pix_valid && pix_ready);
        end
    end

    task automatic do_reset();
        @(posedge sclk); #1;
        rsrt = 1'b0; blk_valid = 1'b0;
        repeat (2) @(posedge sclk);
        #1 rsrt = 1'b1;
        ctxq.delete();
    endtask

    task automatic send_block(input ctx_t c);
        int n = 0;
        cur = c; blk_valid = 1'b1;
        ctxq.push_back(c);
        @(negedge sclk);
        while (!blk_ready && n < 200) begin
            @(negedge sclk);
            n++;
        end
        checks++;
        if (!blk_ready) begin errors++; $display("FAIL send_block blk_ready timeout got %0b want 1", blk_ready); end
        @(posedge sclk); #1 blk_valid = 1'b0;
    endtask

    function automatic ctx_t rand_ctx();
        ctx_t c;
        c.data = {$urandom(), $urandom()};
        c.fl = 1'($urandom_range(0, 1));
        c.pt = 1'($urandom_range(0, 1));
        c.al = 1'($urandom_range(0, 1));
        c.b0 = 24'($urandom());
        c.b1 = 24'($urandom());
        return c;
    endfunction

    task automatic test_reset();
        rsrt = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        checks++;
        if ({blk_ready, dec_rtr, pix_valid, pix_last, frame_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {blk_ready, dec_rtr, pix_valid, pix_last, frame_done});
        end
        checks++;
        if (dec_pixIdx !== 4'd0 || dec_block !== 64'd0 || dec_rsrt !== 1'b1) begin
            errors++; $display("FAIL reset_ctx got idx=%0d blk=%h drst=%b want 0 0 1", dec_pixIdx, dec_block, dec_rsrt);
        end
        rsrt = 1'b1;
        @(negedge sclk);
        checks++;
        if (blk_ready !== 1'b1 || dec_rsrt !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%b drst=%b want 1 0", blk_ready, dec_rsrt);
        end
    endtask

    task automatic test_single_block();
        ctx_t c = rand_ctx();
        do_reset();
        pix_ready = 1'b1;
        send_block(c);
        for (int i = 0; i < 16; i++) begin
            @(negedge sclk);
            checks++;
            if (dec_rtr !== 1'b1 || dec_pixIdx !== 4'(i)) begin
                errors++; $display("FAIL t1_issue%0d got rtr=%b idx=%0d want 1 %0d", i, dec_rtr, dec_pixIdx, i);
            end
            if (i == 0) begin
                checks++;
                if (blk_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_fall got %b want 0", blk_ready); end
            end
            if (i < 2) begin
                checks++;
                if (pix_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid%0d got %b want 0", i, pix_valid); end
            end
            if (i == 2) begin
                checks++;
                if (pix_valid !== 1'b1 || pix_addr !== 8'd0) begin
                    errors++; $display("FAIL t1_first_pix got v=%b addr=%0d want 1 0", pix_valid, pix_addr);
                end
            end
        end
        checks++;
        if (dec_block !== c.data || dec_baseColor_1 !== c.b1) begin
            errors++; $display("FAIL t1_ctx_hold got %h %h want %h %h", dec_block, dec_baseColor_1, c.data, c.b1);
        end
        for (int n = 0; n < 100 && got_q.size() < 16; n++) @(posedge sclk);
        checks++;
        if (got_q.size() !== 16) begin errors++; $display("FAIL t1_count got %0d want 16", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 16; j++) begin
            checks++;
            if (got_q[j].addr !== 8'(exp_addr(j)) || got_q[j].rgba !== gen(c, 4'(j))) begin
                errors++; $display("FAIL t1_pix%0d got addr=%0d rgba=%h want %0d %h", j, got_q[j].addr, got_q[j].rgba, exp_addr(j), gen(c, 4'(j)));
            end
        end
    endtask

    task automatic test_backpressure();
        ctx_t c = rand_ctx();
        do_reset();
        pix_ready = 1'b0;
        send_block(c);
        repeat (12) @(posedge sclk);
        @(negedge sclk);
        checks++;
        if (rtr_n !== D || dec_rtr !== 1'b0 || pix_valid !== 1'b1 || got_q.size() !== 0) begin
            errors++; $display("FAIL t2_stall got issues=%0d rtr=%b v=%b pops=%0d want %0d 0 1 0", rtr_n, dec_rtr, pix_valid, got_q.size(), D);
        end
        @(posedge sclk); #1 pix_ready = 1'b1;
        for (int n = 0; n < 100 && got_q.size() < 16; n++) @(posedge sclk);
        repeat (5) @(posedge sclk);
        checks++;
        if (got_q.size() !== 16 || rtr_n !== 16) begin
            errors++; $display("FAIL t2_count got pops=%0d issues=%0d want 16 16", got_q.size(), rtr_n);
        end
        for (int j = 0; j < got_q.size() && j < 16; j++) begin
            checks++;
            if (got_q[j].addr !== 8'(exp_addr(j)) || got_q[j].rgba !== gen(c, 4'(j))) begin
                errors++; $display("FAIL t2_pix%0d got addr=%0d rgba=%h want %0d %h", j, got_q[j].addr, got_q[j].rgba, exp_addr(j), gen(c, 4'(j)));
            end
        end
    endtask

    task automatic test_frame();
        bit seen[64];
        int bad = 0;
        do_reset();
        pix_ready = 1'b1;
        for (int k = 0; k < 5; k++) send_block(rand_ctx());
        for (int n = 0; n < 300 && got_q.size() < 80; n++) @(posedge sclk);
        repeat (3) @(posedge sclk);
        checks++;
        if (got_q.size() !== 80) begin errors++; $display("FAIL t3_count got %0d want 80", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 80; j++) begin
            if (got_q[j].addr !== 8'(exp_addr(j)) || got_q[j].last !== (j == 63)) bad++;
            if (j < 64 && got_q[j].addr < 64) seen[got_q[j].addr] = 1'b1;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL t3_order got %0d bad pixels want 0", bad); end
        bad = 0;
        for (int a = 0; a < 64; a++) if (!seen[a]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL t3_cover got %0d missing addrs want 0", bad); end
        checks++;
        if (got_q.size() > 64 && (got_q[63].addr !== 8'd63 || got_q[63].last !== 1'b1 || got_q[64].addr !== 8'd0)) begin
            errors++; $display("FAIL t3_wrap got a63=%0d last=%b a64=%0d want 63 1 0", got_q[63].addr, got_q[63].last, got_q[64].addr);
        end
        checks++;
        if (fd_n !== 1) begin errors++; $display("FAIL t3_frame_done got %0d pulses want 1", fd_n); end
    endtask

    task automatic test_mid_reset();
        ctx_t c = rand_ctx();
        int n = 0;
        do_reset();
        pix_ready = 1'b1;
        send_block(rand_ctx());
        send_block(rand_ctx());
        @(negedge sclk);
        while (!(dec_rtr && dec_pixIdx == 4'd7) && n < 100) begin
            @(negedge sclk);
            n++;
        end
        rsrt = 1'b0;
        @(posedge sclk); #1;
        checks++;
        if ({blk_ready, dec_rtr, pix_valid, pix_last, frame_done} !== 5'b0 || dec_pixIdx !== 4'd0 || dec_block !== 64'd0) begin
            errors++; $display("FAIL t4_reset got ctrl=%b idx=%0d blk=%h want 00000 0 0", {blk_ready, dec_rtr, pix_valid, pix_last, frame_done}, dec_pixIdx, dec_block);
        end
        @(posedge sclk); #1 rsrt = 1'b1;
        ctxq.delete();
        send_block(c);
        @(negedge sclk);
        checks++;
        if (dec_rtr !== 1'b1 || dec_pixIdx !== 4'd0) begin
            errors++; $display("FAIL t4_restart got rtr=%b idx=%0d want 1 0", dec_rtr, dec_pixIdx);
        end
        for (int m = 0; m < 100 && got_q.size() < 16; m++) @(posedge sclk);
        repeat (8) @(posedge sclk);
        checks++;
        if (got_q.size() !== 16) begin errors++; $display("FAIL t4_count got %0d want 16", got_q.size()); end
        checks++;
        if (got_q.size() > 15 && (got_q[0].addr !== 8'd0 || got_q[15].rgba !== gen(c, 4'd15))) begin
            errors++; $display("FAIL t4_pix got a0=%0d rgba15=%h want 0 %h", got_q[0].addr, got_q[15].rgba, gen(c, 4'd15));
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        fork
            for (int k = 0; k < 6; k++) send_block(rand_ctx());
            for (int n = 0; n < 3000 && got_q.size() < 96; n++) begin
                @(posedge sclk); #1 pix_ready = 1'($urandom_range(0, 1));
            end
        join
        pix_ready = 1'b1;
        repeat (10) @(posedge sclk);
        checks++;
        if (got_q.size() !== 96) begin errors++; $display("FAIL t5_count got %0d want 96", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 96; j++)
            if (got_q[j].addr !== 8'(exp_addr(j)) || got_q[j].rgba !== gen(ctxq[j / 16], 4'(j % 16))) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL t5_pixels got %0d bad want 0", bad); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL t5_credit got %0d overissues want 0", viol); end
    endtask

    task automatic test_clamp();
        ctx_t c;
        c.data = {24'd0, 6'b111111, 2'b00, 16'hFF00, 16'hFFFF};
        c.fl = 1'b0; c.pt = 1'b0; c.al = 1'b1;
        c.b0 = 24'hFFFFFF; c.b1 = 24'h000000;
        do_reset();
        pix_ready = 1'b1;
        send_block(c);
        for (int n = 0; n < 100 && got_q.size() < 16; n++) @(posedge sclk);
        checks++;
        if (got_q.size() !== 16) begin errors++; $display("FAIL t6_count got %0d want 16", got_q.size()); end
        else begin
            for (int j = 0; j < 16; j++) begin
                checks++;
                if (got_q[j].rgba !== (j < 8 ? 32'hFFFFFFFF : 32'h000000FF)) begin
                    errors++; $display("FAIL t6_clamp%0d got %h want %h", j, got_q[j].rgba, j < 8 ? 32'hFFFFFFFF : 32'h000000FF);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_frame();
        test_mid_reset();
        test_back_to_back();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
